// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word into a 1..2 entry
// elastic buffer whose head drives the registered execute-side outputs.
//
// state | meaning
// EMPTY | no entry buffered, out_valid low
// ONE   | head entry valid
// TWO   | head plus one queued entry (DEPTH=2 only)
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit BYTESWAP = 1'b1,
    parameter int DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      alu_op,
    output logic [4:0]      alu_rs1,
    output logic [4:0]      alu_rs2,
    output logic [4:0]      alu_rd,
    output logic            alu_use_imm,
    output logic            alu_rs1_pc,
    output logic            alu_rs2_neg,
    output logic            alu_res_neg,
    output logic            alu_arith,
    output logic [XLEN-1:0] imm,
    output logic            mem_load,
    output logic            mem_store,
    output logic [2:0]      mem_size,
    output logic            write_enable,
    output logic            jump_enable,
    output logic            jump_reg,
    output logic [1:0]      debug,
    output logic            halted
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      alu_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            use_imm;
        logic            rs1_pc;
        logic            rs2_neg;
        logic            res_neg;
        logic            arith;
        logic [XLEN-1:0] imm;
        logic            mem_load;
        logic            mem_store;
        logic [2:0]      mem_size;
        logic            we;
        logic            je;
        logic            jr;
        logic [1:0]      debug;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    state_t state;
    entry_t e0, e1, dec;
    logic [31:0] instr;
    logic [2:0] f3;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic accept, pop, full_ok;

    assign instr = BYTESWAP ? {in_instr[7:0], in_instr[15:8], in_instr[23:16], in_instr[31:24]}
                            : in_instr;
    assign f3    = instr[14:12];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec     = '0;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        if (instr[1:0] != 2'b11) begin
            dec.debug = 2'b10;
        end else begin
            case (instr[6:2])
                OPC_OP: begin
                    dec.alu_op  = f3;
                    dec.rs2_neg = (f3 == 3'b000) && (instr[31:25] == 7'b0100000);
                    dec.arith   = (f3 == 3'b101) && instr[30];
                    dec.we      = 1'b1;
                end
                OPC_OP_IMM: begin
                    dec.alu_op  = f3;
                    dec.rs2     = '0;
                    dec.use_imm = 1'b1;
                    dec.imm     = XLEN'(imm_i);
                    dec.arith   = (f3 == 3'b101) && instr[30];
                    dec.we      = 1'b1;
                end
                OPC_LOAD: begin
                    dec.rs2      = '0;
                    dec.use_imm  = 1'b1;
                    dec.imm      = XLEN'(imm_i);
                    dec.mem_load = 1'b1;
                    dec.mem_size = f3;
                    dec.we       = 1'b1;
                end
                OPC_STORE: begin
                    dec.rd        = '0;
                    dec.use_imm   = 1'b1;
                    dec.imm       = XLEN'(imm_s);
                    dec.mem_store = 1'b1;
                    dec.mem_size  = f3;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec.rs1     = '0;
                    dec.rs2     = '0;
                    dec.use_imm = 1'b1;
                    dec.rs1_pc  = (instr[6:2] == OPC_AUIPC);
                    dec.imm     = XLEN'(imm_u);
                    dec.we      = 1'b1;
                end
                OPC_JAL: begin
                    dec.rs1     = '0;
                    dec.rs2     = '0;
                    dec.rs1_pc  = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.imm     = XLEN'(imm_j);
                    dec.je      = 1'b1;
                    dec.we      = 1'b1;
                end
                OPC_JALR: begin
                    dec.rs2     = '0;
                    dec.use_imm = 1'b1;
                    dec.imm     = XLEN'(imm_i);
                    dec.je      = 1'b1;
                    dec.jr      = 1'b1;
                    dec.we      = 1'b1;
                    if (f3 != 3'b000) dec.debug = 2'b10;
                end
                OPC_BRANCH: begin
                    dec.rd      = '0;
                    dec.imm     = XLEN'(imm_b);
                    dec.alu_op  = {1'b0, f3[2:1]};
                    dec.rs2_neg = ~f3[2];
                    dec.res_neg = f3[0];
                    dec.je      = 1'b1;
                    if (f3[2:1] == 2'b01) dec.debug = 2'b10;
                end
                OPC_SYSTEM: dec.debug = (instr == 32'h0010_0073) ? 2'b01 : 2'b10;
                default:    dec.debug = 2'b10;
            endcase
        end
        // A debug event carries nothing executable, only its PC and status.
        if (dec.debug != 2'b00) begin
            dec       = '0;
            dec.debug = (instr == 32'h0010_0073) ? 2'b01 : 2'b10;
        end
        dec.pc = in_pc;
    end

    assign out_valid = (state != EMPTY);
    assign pop       = out_valid && out_ready;
    assign full_ok   = (state == EMPTY) || (state == ONE && DEPTH == 2) ||
                       ((DEPTH == 2 ? state == TWO : state == ONE) && out_ready);
    assign in_ready  = rst_n && !halted && full_ok;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state  <= EMPTY;
            halted <= 1'b0;
            e0     <= '0;
            e1     <= '0;
        end else begin
            if (accept && dec.debug != 2'b00) halted <= 1'b1;
            case (state)
                EMPTY: if (accept) begin
                    e0    <= dec;
                    state <= ONE;
                end
                ONE: begin
                    if (accept && pop) begin
                        e0 <= dec;
                    end else if (accept) begin
                        e1    <= dec;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        e0 <= e1;
                        if (accept) e1 <= dec;
                        else        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_pc       = e0.pc;
    assign alu_op       = e0.alu_op;
    assign alu_rs1      = e0.rs1;
    assign alu_rs2      = e0.rs2;
    assign alu_rd       = e0.rd;
    assign alu_use_imm  = e0.use_imm;
    assign alu_rs1_pc   = e0.rs1_pc;
    assign alu_rs2_neg  = e0.rs2_neg;
    assign alu_res_neg  = e0.res_neg;
    assign alu_arith    = e0.arith;
    assign imm          = e0.imm;
    assign mem_load     = e0.mem_load;
    assign mem_store    = e0.mem_store;
    assign mem_size     = e0.mem_size;
    assign write_enable = e0.we;
    assign jump_enable  = e0.je;
    assign jump_reg     = e0.jr;
    assign debug        = e0.debug;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a BYTESWAP=0 instance for the bulk of the
// checks and a BYTESWAP=1 instance for the byte-reversed fetch case.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, alu_use_imm, alu_rs1_pc, alu_rs2_neg, alu_res_neg, alu_arith;
    logic        mem_load, mem_store, write_enable, jump_enable, jump_reg, halted;
    logic [31:0] out_pc, imm;
    logic [2:0]  alu_op, mem_size;
    logic [4:0]  alu_rs1, alu_rs2, alu_rd;
    logic [1:0]  debug;

    logic        b_in_valid;
    logic [31:0] b_in_instr;
    logic        b_in_ready, b_out_valid, b_use_imm, b_rs1_pc, b_rs2_neg, b_res_neg, b_arith;
    logic        b_mem_load, b_mem_store, b_we, b_je, b_jr, b_halted;
    logic [31:0] b_out_pc, b_imm;
    logic [2:0]  b_alu_op, b_mem_size;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [1:0]  b_debug;

    decode_stage #(.XLEN(32), .BYTESWAP(1'b0), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .alu_op(alu_op), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_rd(alu_rd), .alu_use_imm(alu_use_imm), .alu_rs1_pc(alu_rs1_pc),
        .alu_rs2_neg(alu_rs2_neg), .alu_res_neg(alu_res_neg), .alu_arith(alu_arith), .imm(imm),
        .mem_load(mem_load), .mem_store(mem_store), .mem_size(mem_size),
        .write_enable(write_enable), .jump_enable(jump_enable), .jump_reg(jump_reg),
        .debug(debug), .halted(halted)
    );

    decode_stage #(.XLEN(32), .BYTESWAP(1'b1), .DEPTH(2)) dut_bs (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_out_pc), .alu_op(b_alu_op), .alu_rs1(b_rs1),
        .alu_rs2(b_rs2), .alu_rd(b_rd), .alu_use_imm(b_use_imm), .alu_rs1_pc(b_rs1_pc),
        .alu_rs2_neg(b_rs2_neg), .alu_res_neg(b_res_neg), .alu_arith(b_arith), .imm(b_imm),
        .mem_load(b_mem_load), .mem_store(b_mem_store), .mem_size(b_mem_size),
        .write_enable(b_we), .jump_enable(b_je), .jump_reg(b_jr),
        .debug(b_debug), .halted(b_halted)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; b_in_valid = 1'b0; b_in_instr = '0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        chk("reset_imm", 64'(imm), 64'd0);
        chk("reset_debug", 64'(debug), 64'd0);
        chk("reset_we", 64'(write_enable), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // byte-reversed addi x1,x0,-1
        b_in_valid = 1'b1; b_in_instr = 32'h9300F0FF;
        tick();
        b_in_valid = 1'b0;
        chk("bs_valid", 64'(b_out_valid), 64'd1);
        chk("bs_rd", 64'(b_rd), 64'd1);
        chk("bs_rs1", 64'(b_rs1), 64'd0);
        chk("bs_use_imm", 64'(b_use_imm), 64'd1);
        chk("bs_imm", 64'(b_imm), 64'hFFFF_FFFF);
        chk("bs_we", 64'(b_we), 64'd1);
        chk("bs_debug", 64'(b_debug), 64'd0);

        // streaming, out_ready high: sub, lui, beq, sw
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h100;
        tick();
        in_instr = 32'h123452B7; in_pc = 32'h104;
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_alu_op", 64'(alu_op), 64'd0);
        chk("sub_neg", 64'(alu_rs2_neg), 64'd1);
        chk("sub_regs", 64'({alu_rs1, alu_rs2, alu_rd}), 64'({5'd1, 5'd2, 5'd3}));
        chk("sub_pc", 64'(out_pc), 64'h100);
        tick();
        in_instr = 32'hFE208CE3; in_pc = 32'h108;
        chk("lui_imm", 64'(imm), 64'h1234_5000);
        chk("lui_rs1", 64'(alu_rs1), 64'd0);
        chk("lui_rd_we", 64'({alu_rd, write_enable}), 64'({5'd5, 1'b1}));
        tick();
        in_instr = 32'h0020A223; in_pc = 32'h10C;
        chk("beq_imm", 64'(imm), 64'hFFFF_FFF8);
        chk("beq_ctl", 64'({alu_op, alu_rs2_neg, alu_res_neg, jump_enable, write_enable}),
            64'({3'd0, 1'b1, 1'b0, 1'b1, 1'b0}));
        tick();
        in_valid = 1'b0;
        chk("sw_imm", 64'(imm), 64'd4);
        chk("sw_ctl", 64'({mem_store, mem_load, mem_size, write_enable}),
            64'({1'b1, 1'b0, 3'd2, 1'b0}));
        tick();
        chk("stream_drained", 64'(out_valid), 64'd0);

        // stall: three offered, two accepted, head stable
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
        tick();
        in_instr = 32'h00200113; in_pc = 32'h204;
        tick();
        in_instr = 32'h00300193; in_pc = 32'h208;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        chk("stall_head_pc", 64'(out_pc), 64'h200);
        chk("stall_head_imm", 64'(imm), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("fifo_2nd_pc", 64'(out_pc), 64'h204);
        chk("fifo_2nd_imm", 64'(imm), 64'd2);
        tick();
        chk("fifo_3rd_pc", 64'(out_pc), 64'h208);
        chk("fifo_3rd_rd", 64'(alu_rd), 64'd3);
        tick();
        chk("fifo_empty", 64'(out_valid), 64'd0);

        // ebreak halts intake until flush
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100073; in_pc = 32'h300;
        tick();
        in_instr = 32'h00500293; in_pc = 32'h304;
        chk("brk_debug", 64'(debug), 64'd1);
        chk("brk_halted", 64'(halted), 64'd1);
        chk("brk_enables", 64'({write_enable, jump_enable, mem_load, mem_store}), 64'd0);
        #1;
        chk("halt_in_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        chk("halt_head_pc", 64'(out_pc), 64'h300);
        out_ready = 1'b1;
        tick();
        chk("halt_drain", 64'(out_valid), 64'd0);
        chk("halt_kept", 64'(halted), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_halted", 64'(halted), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        #1;
        chk("resume_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("resume_pc", 64'(out_pc), 64'h304);
        chk("resume_rd", 64'(alu_rd), 64'd5);
        tick();

        // flush alongside an accept with two buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
        tick();
        in_instr = 32'h00200113; in_pc = 32'h404;
        tick();
        in_instr = 32'h00300193; in_pc = 32'h408;
        out_ready = 1'b1; flush = 1'b1;
        #1;
        chk("flush_cycle_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_empty", 64'(out_valid), 64'd0);
        tick();
        chk("flush2_word_absent", 64'(out_valid), 64'd0);

        // all-zero word is illegal
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000_0000; in_pc = 32'h500;
        tick();
        in_valid = 1'b0;
        chk("ill_debug", 64'(debug), 64'd2);
        chk("ill_enables", 64'({write_enable, jump_enable, jump_reg, mem_load, mem_store}), 64'd0);
        chk("ill_halted", 64'(halted), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // jal, then reset while stalled
        in_valid = 1'b1; in_instr = 32'h008000EF; in_pc = 32'h600;
        tick();
        in_valid = 1'b0;
        chk("jal_imm", 64'(imm), 64'd8);
        chk("jal_ctl", 64'({alu_rs1_pc, jump_enable, jump_reg, write_enable, alu_rd}),
            64'({1'b1, 1'b1, 1'b0, 1'b1, 5'd1}));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midstall_reset", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined RV32I decode stage: one registered output stage plus a 2-entry elastic buffer between fetch and execute, with valid/ready on both sides.
- Decodes OP, OP_IMM, LOAD, STORE, BRANCH, JAL, plus JALR, LUI and AUIPC; produces ALU/memory/writeback/jump controls with the PC passed through.
- Halts intake after a debug event (EBREAK or illegal instruction) until flushed.

Parameters:
- XLEN, 32, datapath and immediate width (32 or 64); immediates sign-extended to XLEN.
- BYTESWAP, 1, 1 = in_instr arrives byte-reversed and is swapped before decode; 0 = decoded as-is.
- DEPTH, 2, output buffer entries (1 or 2; 1 = no back-to-back throughput under stall).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  fetch offers in_instr/in_pc.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  drop all buffered entries, clear halt.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes head.
- out_pc  out  XLEN  PC of head entry.
- alu_op  out  3  ALU function.
- alu_rs1, alu_rs2, alu_rd  out  5 each  register indices.
- alu_use_imm, alu_rs1_pc, alu_rs2_neg, alu_res_neg, alu_arith  out  1 each  operand/result modifiers (alu_arith = arithmetic right shift).
- imm  out  XLEN  decoded immediate.
- mem_load, mem_store  out  1 each; mem_size  out  3  funct3 of LOAD/STORE, else 0.
- write_enable, jump_enable, jump_reg  out  1 each.
- debug  out  2  00 OK, 01 BREAK, 10 FAIL.
- halted  out  1  intake stopped by debug event.

Behaviour:
- Reset (rst_n=0 at posedge): buffer empty, out_valid=0, halted=0, in_ready=0 during the reset cycle; all decoded outputs 0, debug=00.
- Accept when in_valid & in_ready. in_ready = ~halted & (count<DEPTH | (count==DEPTH & out_ready)).
- Latency: an accepted instruction appears at the head the next cycle when the buffer is empty. Order is FIFO. Head outputs hold stable while out_valid & ~out_ready.
- Buffer count states: EMPTY -> ONE on accept; ONE -> EMPTY on pop without accept; ONE -> TWO on accept without pop; simultaneous accept+pop keeps count; TWO -> ONE on pop.
- Decode uses opcode[6:2] and requires instr[1:0]=11; otherwise FAIL.
- OP: rs1/rs2/rd from fields, alu_op=funct3, alu_rs2_neg = (funct3==000 & funct7==0100000), alu_arith = (funct3==101 & funct7[5]), write_enable=1.
- OP_IMM: imm=I, alu_use_imm=1, alu_rs2=0, alu_rs2_neg=0, alu_arith as OP, write_enable=1.
- LOAD: alu_op=0, imm=I, mem_load=1, write_enable=1. STORE: imm=S, mem_store=1, write_enable=0.
- LUI: alu_rs1=0, alu_use_imm=1, imm=U (instr[31:12]<<12, sign-extended), write_enable=1. AUIPC: as LUI with alu_rs1_pc=1.
- JAL: alu_rs1_pc=1, imm=J (bit 0 = 0), jump_enable=1, write_enable=1. JALR (funct3 must be 000): alu_rs1=rs1, imm=I, jump_enable=1, jump_reg=1, write_enable=1.
- BRANCH: imm=B (bit 0 = 0), alu_op={0,funct3[2:1]}, alu_rs2_neg=~funct3[2], alu_res_neg=funct3[0], alu_rd=0, jump_enable=1. funct3 010/011 is FAIL.
- SYSTEM: EBREAK (0x00100073) gives BREAK; anything else gives FAIL.
- Any FAIL or BREAK: all enables 0.
- Accepting a BREAK/FAIL instruction sets halted the next cycle; in_ready then 0 until flush. Entries already buffered still drain.
- flush at posedge: count cleared to EMPTY, out_valid=0, halted=0. flush wins over a simultaneous accept or pop (the incoming word is dropped). in_ready during the flush cycle is still computed normally, but nothing is stored.
- Reset asserted mid-stall discards all entries, same as a flush.

Test Plan:
- Reset, then one word with BYTESWAP=1: in_instr=0x9300F0FF (addi x1,x0,-1) -> next cycle out_valid=1, rd=1, rs1=0, alu_use_imm=1, imm=0xFFFFFFFF, write_enable=1, debug=00.
- sub x3,x1,x2 (0x402081B3, BYTESWAP=0) -> alu_op=0, alu_rs2_neg=1, rs1=1, rs2=2, rd=3; lui x5,0x12345 (0x123452B7) -> imm=0x12345000, alu_rs1=0.
- beq x1,x2,-8 (0xFE208CE3) -> imm=0xFFFFFFF8, alu_op=0, alu_rs2_neg=1, alu_res_neg=0, jump_enable=1, write_enable=0.
- Hold out_ready=0 and stream 3 instructions -> 2 accepted, in_ready=0 on the third, head stable. Release -> FIFO order, one pop per cycle, no loss or duplication.
- Send ebreak (0x00100073) then addi -> debug=01, halted=1, the addi is not accepted. Assert flush -> out_valid=0, halted=0, intake resumes.
- Assert flush in the same cycle as an accept with 2 buffered -> buffer empty next cycle, flushed word absent. Also send 0x00000000 -> debug=10, all enables 0.
